// File: rtl/mem_io_responder.sv
// Purpose : memory-side responder for the byte-serial bus: RAM plus I/O window (TX FIFO, RX holding reg, halt).
// Latency : one cycle; mem_din and io_buffer_full are registered, tx_data/tx_valid come straight from FIFO state.
// Backpressure: TX FIFO drops pushes when full (unless popped the same cycle); io_buffer_full warns early.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   mem_a, mem_dout, mem_wr   address / write data / write strobe from the memory controller
//   mem_din               registered read data back to the controller
//   io_buffer_full        registered TX near-full flag
//   tx_data, tx_valid, tx_ready   UART transmit side (head of TX FIFO)
//   rx_data, rx_valid     UART receive strobe
//   halt                  sticky end-of-run flag
module mem_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        halt
);

    localparam int CW    = TX_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [CW-1:0] TX_DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] TX_NEAR_LEVEL = CW'(DEPTH - FULL_MARGIN);

    // Only mem_a[17:0] carries meaning on this bus.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_a[31:18]};

    // Address decode
    logic                  io;
    logic [2:0]            off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  rd_rx, rd_stat, wr_tx, wr_halt;

    assign io      = (mem_a[17:16] == 2'b11);
    assign off     = mem_a[2:0];
    assign idx     = mem_a[ADDR_WIDTH-1:0];
    assign rd_rx   = io && !mem_wr && (off == 3'd0);
    assign rd_stat = io && !mem_wr && (off == 3'd4);
    assign wr_tx   = io &&  mem_wr && (off == 3'd0);
    assign wr_halt = io &&  mem_wr && (off == 3'd4);

    // RAM: contents are deliberately not reset.
    logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (mem_wr && !io) begin
            ram[idx] <= mem_dout;
        end
    end

    // TX FIFO
    logic [7:0]               tx_mem [0:DEPTH-1];
    logic [TX_DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0]            count, count_next;
    logic                     tx_full, tx_push, tx_pop;

    assign tx_valid   = (count != '0);
    assign tx_data    = tx_mem[rd_ptr];
    assign tx_full    = (count == TX_DEPTH_C);
    assign tx_pop     = tx_valid && tx_ready;
    // A full FIFO still accepts a push when a slot frees up on the same edge.
    assign tx_push    = wr_tx && (!tx_full || tx_pop);
    assign count_next = count + CW'(tx_push) - CW'(tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[wr_ptr] <= mem_dout;
        end
    end

    // RX holding register. The pop is qualified by prev_rd_io so a stalled
    // (held) read of the data port consumes the byte only once.
    logic       rx_full, prev_rd_io;
    logic [7:0] rx_byte;
    logic       rx_pop, rx_cap;

    assign rx_pop = rd_rx && !prev_rd_io;
    assign rx_cap = rx_valid && (!rx_full || rx_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_din        <= 8'h00;
            io_buffer_full <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            rx_full        <= 1'b0;
            rx_byte        <= 8'h00;
            prev_rd_io     <= 1'b0;
            halt           <= 1'b0;
        end else begin
            prev_rd_io     <= rd_rx;
            count          <= count_next;
            // Early warning so the controller, which samples a cycle late, never overruns.
            io_buffer_full <= (count_next >= TX_NEAR_LEVEL);
            if (tx_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_halt) halt   <= 1'b1;

            // A capture colliding with a pop refills the register; the read
            // below still sees the old byte because it samples rx_byte now.
            if (rx_cap) begin
                rx_byte <= rx_data;
                rx_full <= 1'b1;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end

            if (!mem_wr) begin
                if (!io) begin
                    mem_din <= ram[idx];
                end else if (rd_rx) begin
                    // Repeat cycles of a held read keep returning the popped byte.
                    if (rx_pop) mem_din <= rx_full ? rx_byte : 8'h00;
                end else if (rd_stat) begin
                    mem_din <= {6'b0, ~tx_valid, rx_full};
                end else begin
                    mem_din <= 8'h00;
                end
            end
        end
    end

endmodule
